// File: rtl/logic_unit_pipe.sv
// Registered eight-op bitwise unit with accumulate mode, result flags and saturating txn counter.
// Latency: one cycle. An input accepted at edge N has its result, flags and out_valid visible after edge N.
// Backpressure: single output register with no skid. in_ready drops while a result is held and out_ready is low.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NOTB = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] acc_reg_q, acc_reg_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] result;

    // Only one output register, so a new input can land only when that slot is empty or draining.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    // Clearing the accumulator wins over reading it when both happen in the same cycle.
    assign opa = acc_mode ? (acc_clr ? '0 : acc_reg_q) : a;

    // Bitwise function of the selected operands.
    always_comb begin
        result = '0;
        unique case (op)
            OP_AND:  result = opa & b;
            OP_OR:   result = opa | b;
            OP_NOTA: result = ~opa;
            OP_NOTB: result = ~b;
            OP_NAND: result = ~(opa & b);
            OP_NOR:  result = ~(opa | b);
            OP_XOR:  result = opa ^ b;
            OP_XNOR: result = ~(opa ^ b);
            default: result = '0;
        endcase
    end

    // Next-state for output register, flags, accumulator and counter.
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
        acc_reg_d   = acc_reg_q;
        txn_cnt_d   = txn_cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            y_d         = result;
            zero_d      = (result == '0);
            ones_d      = (result == '1);
            parity_d    = ^result;
            if (txn_cnt_q != '1) begin
                txn_cnt_d = txn_cnt_q + 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        if (accept && acc_mode) begin
            acc_reg_d = result;
        end else if (acc_clr) begin
            acc_reg_d = '0;
        end
    end

    // State registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            acc_reg_q   <= '0;
            txn_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            acc_reg_q   <= acc_reg_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign parity    = parity_q;
    assign acc_q     = acc_reg_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the two-input dataflow gate block.
- Applies one of eight bitwise ops (AND, OR, NOT A, NOT B, NAND, NOR, XOR, XNOR) to WIDTH-bit vectors.
- Valid/ready handshake on input and output, so it chains into streaming datapaths.
- Adds an accumulate mode (operand A taken from an internal register), registered result flags, and a saturating transaction counter.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 8, width of accepted-transaction counter (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
a  input  WIDTH  operand A (ignored when acc_mode=1)
b  input  WIDTH  operand B
op  input  3  0 AND, 1 OR, 2 NOT A, 3 NOT B, 4 NAND, 5 NOR, 6 XOR, 7 XNOR
acc_mode  input  1  1: operand A = internal accumulator
acc_clr  input  1  clear accumulator (sampled every cycle, no handshake)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
y  output  WIDTH  registered result
zero  output  1  y == 0
ones  output  1  y == all ones
parity  output  1  XOR-reduction of y
acc_q  output  WIDTH  current accumulator value
txn_cnt  output  CNT_W  accepted input transactions, saturating

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, y=0, zero=1, ones=0, parity=0, acc_q=0, txn_cnt=0.
  - Reset overrides all other inputs.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single output register, no skid).
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Latency:
  - Input accepted at edge N gives y/flags and out_valid=1 after edge N.
  - Throughput is 1 transaction/cycle while out_ready=1.
- Stall:
  - out_valid=1 && out_ready=0 forces in_ready=0.
  - y and flags hold stable until consumed.
- Each edge, unless reset:
  - accept -> out_valid<=1, y<=f(op, opA, b), flags computed from the new y.
  - consume without accept -> out_valid<=0; y and flags hold last value.
- Operand A:
  - opA = acc_mode ? (acc_clr ? 0 : acc_q) : a.
  - acc_clr therefore takes effect before operand selection in the same cycle.
- NOT A / NOT B: the other operand is ignored.
- Accumulator update:
  - accept with acc_mode=1 -> acc_q <= new result (whether or not acc_clr is high).
  - else acc_clr=1 -> acc_q <= 0.
  - else acc_q holds.
  - acc_mode=1 with no accept leaves acc_q unchanged.
- txn_cnt:
  - +1 on every accept.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by rst.
- Flags are registered alongside y, never combinational from inputs.
- op, acc_mode and b are sampled only on accept; changes while in_valid=0 or in_ready=0 have no effect.
- Reset mid-stall: a pending result is discarded; out_valid=0 on the next cycle.
- WIDTH=1: zero = !y, ones = y, parity = y.

Test Plan:
- Truth table, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC, op 0..7 on consecutive cycles -> y = C0, FC, 0F, 33, 3F, 03, 3C, C3 one cycle after each accept. Check parity for each (C0->0, FC->0, 0F->0, 33->0, 3F->0, 03->0, 3C->0, C3->0), zero=0 and ones=0 throughout, txn_cnt=8.
- Backpressure: accept a=8'hFF, b=8'h00, op=OR, hold out_ready=0 for 3 cycles with in_valid=1 and a new a=8'h00 -> in_ready=0, y=8'hFF, ones=1 held for 3 cycles. Release out_ready -> first result consumed, next accepted, then y=8'h00, zero=1.
- Accumulate: acc_clr=1 with acc_mode=1, op=XOR, b=8'h0F -> acc_q=8'h0F. Then op=XOR, b=8'hFF -> acc_q=8'hF0. Then op=AND, b=8'h30 -> y=8'h30, acc_q=8'h30. Then acc_clr alone (in_valid=0) -> acc_q=8'h00.
- Counter saturation: CNT_W=2, 6 back-to-back accepts -> txn_cnt sequence 1, 2, 3, 3, 3, 3.
- Reset mid-operation: out_valid=1, out_ready=0, acc_q=8'hAA, assert rst one cycle -> next cycle out_valid=0, y=0, zero=1, acc_q=0, txn_cnt=0, in_ready=1.
- Ignored inputs: in_valid=0 while toggling a, b, op, acc_mode for 5 cycles -> y, flags, acc_q and txn_cnt all unchanged.
